multi_counter: RTL and testbench
================================

# multi_counter

Parametrised, multi-channel successor to the team's 2-bit free-running counter, and a triplication target for the TMR flow. Provides CHANNELS independent WIDTH-bit up/down counters sharing one clock, a programmable limit, and a wrap or saturate mode. Each channel supports synchronous clear and parallel load, a registered terminal-count pulse and a sticky overflow flag. Counters feed downstream datapath logic in the top level, replacing per-site hand-written counters.

## Interface
- WIDTH, 8: bits per channel counter (>=2)
- CHANNELS, 4: number of independent counters (>=1)
- SATURATE, 0: 0 = wrap at boundary, 1 = hold at boundary
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_clr  in  CHANNELS  per-channel synchronous clear to 0
- i_load  in  CHANNELS  per-channel synchronous parallel load
- i_load_value  in  CHANNELS*WIDTH  load data; channel c at bits [c*WIDTH +: WIDTH]
- i_en  in  CHANNELS  per-channel count enable
- i_up  in  CHANNELS  direction: 1 = increment, 0 = decrement
- i_limit  in  WIDTH  shared upper bound; legal count range is 0..i_limit
- i_flag_clr  in  CHANNELS  per-channel clear of o_ovf
- o_count  out  CHANNELS*WIDTH  registered counts, same packing as i_load_value
- o_tc  out  CHANNELS  registered one-cycle terminal-count pulse
- o_ovf  out  CHANNELS  sticky boundary-crossing flag

## Operation
- Channels are fully independent; the only shared input is i_limit.
- Per-channel priority each cycle: i_clr > i_load > i_en > hold.
- Clear: count <- 0. No o_tc, no o_ovf change.
- Load: count <- min(i_load_value[c], i_limit). No o_tc.
- Enabled step with count > i_limit (limit lowered at runtime): count <- i_limit in either direction. No o_tc.
- Up step, count < i_limit: count + 1.
- Up step, count == i_limit: boundary. Wrap mode gives 0; saturate mode holds i_limit.
- Down step, count > 0: count - 1.
- Down step, count == 0: boundary. Wrap mode gives i_limit; saturate mode holds 0.
- Boundary event: o_tc[c] = 1 for exactly the next cycle and o_ovf[c] set. This applies in saturate mode too, on every enabled step at the boundary, including repeated steps.
- o_ovf[c] is cleared by i_flag_clr[c]. A set on the same cycle wins over the clear. i_clr does not clear o_ovf.
- i_limit = 0: every enabled step is a boundary; count stays 0.
- All arithmetic is WIDTH bits unsigned. No internal carry wider than WIDTH is exposed.

## Timing
- Reset (i_rst_n low): o_count = 0, o_tc = 0, o_ovf = 0 on all channels, immediately and asynchronously. Reset is released synchronously through the design's reset synchroniser upstream.
- Inputs are sampled on the rising edge of i_clk. o_count, o_tc and o_ovf update on that same edge, a latency of 1 cycle.
- o_tc is asserted in the same cycle that o_count shows the post-boundary value. It is never high for 2 cycles unless boundary steps occur on consecutive cycles.
- Reset mid-operation aborts any step. The first edge after release behaves as from count 0.
- No combinational path from any input to any output.

## Test plan
- Reset: assert i_rst_n = 0 mid-count with CHANNELS = 4, WIDTH = 8 -> all o_count = 0x00, o_tc = 0, o_ovf = 0 without waiting for a clock edge.
- Wrap up: SATURATE = 0, i_limit = 5, i_up = 1, i_en = 1 for 8 cycles from 0 -> count sequence 1,2,3,4,5,0,1,2. o_tc high only with count 0. o_ovf high from then on.
- Saturate down: SATURATE = 1, load 2, i_up = 0, enable 4 cycles -> 1,0,0,0. o_tc high on the 3rd and 4th cycles. i_flag_clr pulse then clears o_ovf.
- Priority: same cycle i_clr = 1, i_load = 1 (value 0x33), i_en = 1 -> count 0. Next cycle load-only -> 0x33 (i_limit = 0xFF). Load 0x40 with i_limit = 0x20 -> 0x20.
- Runtime limit: count 200, i_limit changed to 100, one enabled down step -> count 100, o_tc = 0. Next up step -> wrap to 0, o_tc = 1.
- Channel isolation / flag race: ch0 boundary while ch1 counts and ch2 has i_flag_clr together with a boundary -> ch1 unaffected, ch2 o_ovf stays 1, ch3 holds.

Source files
------------

// File: rtl/multi_counter_if.sv
// Bus bundle for multi_counter: per-channel controls in, registered counts and flags out.
interface multi_counter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       i_clr;
  logic [CHANNELS-1:0]       i_load;
  logic [CHANNELS*WIDTH-1:0] i_load_value;
  logic [CHANNELS-1:0]       i_en;
  logic [CHANNELS-1:0]       i_up;
  logic [WIDTH-1:0]          i_limit;
  logic [CHANNELS-1:0]       i_flag_clr;
  logic [CHANNELS*WIDTH-1:0] o_count;
  logic [CHANNELS-1:0]       o_tc;
  logic [CHANNELS-1:0]       o_ovf;

  modport master (
    output i_clr, i_load, i_load_value, i_en, i_up, i_limit, i_flag_clr,
    input  o_count, o_tc, o_ovf
  );

  modport slave (
    input  i_clr, i_load, i_load_value, i_en, i_up, i_limit, i_flag_clr,
    output o_count, o_tc, o_ovf
  );
endinterface

// File: rtl/multi_counter.sv
// CHANNELS independent WIDTH-bit up/down counters with a shared limit,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module multi_counter_lane #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             flag_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             bnd;

  always_comb begin
    cnt_d = cnt_q;
    bnd   = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (load_value_i > limit_i) ? limit_i : load_value_i;
    end else if (en_i) begin
      // Limit lowered below the current count: snap back into range, not a boundary.
      if (cnt_q > limit_i) begin
        cnt_d = limit_i;
      end else if (up_i) begin
        if (cnt_q == limit_i) begin
          bnd   = 1'b1;
          cnt_d = SATURATE ? limit_i : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          bnd   = 1'b1;
          cnt_d = SATURATE ? '0 : limit_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
    tc_d  = bnd;
    ovf_d = bnd | (ovf_q & ~flag_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o = cnt_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
endmodule

module multi_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  multi_counter_if.slave bus
);
  logic [CHANNELS-1:0][WIDTH-1:0] cnt;
  logic [CHANNELS-1:0]            tc;
  logic [CHANNELS-1:0]            ovf;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    multi_counter_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk_i        (i_clk),
      .rst_ni       (i_rst_n),
      .clr_i        (bus.i_clr[c]),
      .load_i       (bus.i_load[c]),
      .load_value_i (bus.i_load_value[c*WIDTH +: WIDTH]),
      .en_i         (bus.i_en[c]),
      .up_i         (bus.i_up[c]),
      .limit_i      (bus.i_limit),
      .flag_clr_i   (bus.i_flag_clr[c]),
      .count_o      (cnt[c]),
      .tc_o         (tc[c]),
      .ovf_o        (ovf[c])
    );
  end

  assign bus.o_count = cnt;
  assign bus.o_tc    = tc;
  assign bus.o_ovf   = ovf;
endmodule

// File: tb/tb_multi_counter.sv
// Directed bench: wrap-mode and saturate-mode instances, vector table on ch0 of the
// wrap instance plus hand sequences for saturation, channel isolation and async reset.
module tb_multi_counter;
  localparam int W = 8;
  localparam int C = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  multi_counter_if #(.WIDTH(W), .CHANNELS(C)) bw ();
  multi_counter_if #(.WIDTH(W), .CHANNELS(C)) bs ();

  multi_counter #(.WIDTH(W), .CHANNELS(C), .SATURATE(1'b0)) u_wrap (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bw.slave)
  );
  multi_counter #(.WIDTH(W), .CHANNELS(C), .SATURATE(1'b1)) u_sat (
    .i_clk (clk), .i_rst_n (rst_n), .bus (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr, load, en, up, fclr;
    logic [W-1:0] lv, lim;
    logic [W-1:0] e_cnt;
    logic         e_tc, e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic load, logic [W-1:0] lv, logic en, logic up,
                              logic [W-1:0] lim, logic fclr,
                              logic [W-1:0] e_cnt, logic e_tc, logic e_ovf);
    vec_t v;
    v.clr = clr; v.load = load; v.lv = lv; v.en = en; v.up = up;
    v.lim = lim; v.fclr = fclr; v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bw.i_clr = '0; bw.i_load = '0; bw.i_load_value = '0; bw.i_en = '0;
    bw.i_up = '0; bw.i_limit = '0; bw.i_flag_clr = '0;
    bs.i_clr = '0; bs.i_load = '0; bs.i_load_value = '0; bs.i_en = '0;
    bs.i_up = '0; bs.i_limit = '0; bs.i_flag_clr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cw(input int c);
    return bw.o_count[c*W +: W];
  endfunction

  function automatic logic [W-1:0] cs(input int c);
    return bs.o_count[c*W +: W];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_all();
    rst_n = 1'b0;
    #2;
    chk("rst_cnt_wrap", bw.o_count, 32'h0);
    chk("rst_flags_wrap", {bw.o_tc, bw.o_ovf}, 32'h0);
    chk("rst_cnt_sat", bs.o_count, 32'h0);
    #10 rst_n = 1'b1;

    // clr load lv en up lim fclr | cnt tc ovf   (wrap instance, channel 0)
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd1,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd2,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd3,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd4,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd5,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd0,1,1));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd1,0,1));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,0, 8'd2,0,1));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd5,1, 8'd3,0,0));
    vecs.push_back(mk(1,1,8'h33,1,1,8'hFF,0, 8'h00,0,0));
    vecs.push_back(mk(0,1,8'h33,0,1,8'hFF,0, 8'h33,0,0));
    vecs.push_back(mk(0,1,8'h40,0,1,8'h20,0, 8'h20,0,0));
    vecs.push_back(mk(0,1,8'd200,0,1,8'hFF,0, 8'd200,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'd100,0, 8'd100,0,0));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd100,0, 8'd0,1,1));
    vecs.push_back(mk(1,0,8'h00,0,1,8'd100,0, 8'd0,0,1));
    vecs.push_back(mk(0,0,8'h00,1,1,8'd0,1, 8'd0,1,1));
    vecs.push_back(mk(0,0,8'h00,0,1,8'd0,1, 8'd0,0,0));
    vecs.push_back(mk(0,0,8'h00,1,0,8'd0,0, 8'd0,1,1));
    vecs.push_back(mk(0,0,8'h00,0,0,8'd5,0, 8'd0,0,1));
    vecs.push_back(mk(0,0,8'h00,1,0,8'd5,0, 8'd5,1,1));

    foreach (vecs[i]) begin
      bw.i_clr        = {3'b0, vecs[i].clr};
      bw.i_load       = {3'b0, vecs[i].load};
      bw.i_load_value = {24'h0, vecs[i].lv};
      bw.i_en         = {3'b0, vecs[i].en};
      bw.i_up         = {3'b0, vecs[i].up};
      bw.i_limit      = vecs[i].lim;
      bw.i_flag_clr   = {3'b0, vecs[i].fclr};
      step();
      chk($sformatf("vec%0d_cnt", i), cw(0), vecs[i].e_cnt);
      chk($sformatf("vec%0d_tc", i), bw.o_tc[0], vecs[i].e_tc);
      chk($sformatf("vec%0d_ovf", i), bw.o_ovf[0], vecs[i].e_ovf);
      chk($sformatf("vec%0d_others", i), {bw.o_count[C*W-1:W], bw.o_tc[C-1:1], bw.o_ovf[C-1:1]}, 32'h0);
    end
    idle_all();

    // Saturate down from 2: 1,0,0,0 with tc on the last two steps
    bs.i_load = 4'b0001; bs.i_load_value = 32'h2; bs.i_limit = 8'hFF;
    step();
    chk("sat_load", cs(0), 8'd2);
    bs.i_load = '0; bs.i_en = 4'b0001; bs.i_up = '0;
    step(); chk("sat_dn1", {cs(0), bs.o_tc[0]}, {8'd1, 1'b0});
    step(); chk("sat_dn2", {cs(0), bs.o_tc[0]}, {8'd0, 1'b0});
    step(); chk("sat_dn3", {cs(0), bs.o_tc[0], bs.o_ovf[0]}, {8'd0, 1'b1, 1'b1});
    step(); chk("sat_dn4", {cs(0), bs.o_tc[0], bs.o_ovf[0]}, {8'd0, 1'b1, 1'b1});
    bs.i_en = '0; bs.i_flag_clr = 4'b0001;
    step(); chk("sat_fclr", {cs(0), bs.o_tc[0], bs.o_ovf[0]}, {8'd0, 1'b0, 1'b0});
    bs.i_flag_clr = '0;
    bs.i_load = 4'b0010; bs.i_load_value = 32'h0000_0900; bs.i_limit = 8'd3;
    step(); chk("sat_ld_clamp", cs(1), 8'd3);
    bs.i_load = '0; bs.i_en = 4'b0010; bs.i_up = 4'b0010;
    step(); chk("sat_up1", {cs(1), bs.o_tc[1]}, {8'd3, 1'b1});
    step(); chk("sat_up2", {cs(1), bs.o_tc[1], bs.o_ovf[1]}, {8'd3, 1'b1, 1'b1});
    bs.i_en = '0;
    step(); chk("sat_tc_drop", bs.o_tc[1], 1'b0);

    // Channel isolation and flag set-vs-clear race
    bw.i_limit = 8'd5;
    bw.i_load = 4'b1111; bw.i_load_value = {8'd4, 8'd5, 8'd2, 8'd5};
    step(); chk("iso_load", bw.o_count, {8'd4, 8'd5, 8'd2, 8'd5});
    bw.i_load = '0;
    bw.i_en = 4'b0111; bw.i_up = 4'b0111; bw.i_flag_clr = 4'b0100;
    step();
    chk("iso_cnt", bw.o_count, {8'd4, 8'd0, 8'd3, 8'd0});
    chk("iso_tc", bw.o_tc, 4'b0101);
    chk("iso_ovf", bw.o_ovf, 4'b0101);
    bw.i_en = 4'b0010; bw.i_flag_clr = '0;
    step();
    chk("iso_tc_pulse", {bw.o_tc, cw(1)}, {4'b0000, 8'd4});

    // Asynchronous reset mid-count, checked before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cnt", bw.o_count, 32'h0);
    chk("arst_flags", {bw.o_tc, bw.o_ovf, bs.o_tc, bs.o_ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_step", cw(1), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
